spi_count_ctrl: RTL

- Command and counter stage directly downstream of the SPI slave.
- Consumes the byte the slave presents on data_incoming after each chip-select release and decodes it as a command.
- Maintains an event counter clocked from the board clock, and drives data_outgoing, which the slave loads at the next ce0 fall.
- Response to command byte N is therefore shifted out during SPI transaction N+1.

---
 rtl/spi_count_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_count_ctrl.sv
// Command decoder and prescaled event counter sitting behind the SPI slave.
// Decodes one byte per chip-select release; the response is shifted out in the next transaction.
module spi_count_ctrl #(
  parameter int CNT_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ce0,
  input  logic [7:0] data_incoming,
  input  logic       event_in,
  output logic [7:0] data_outgoing,
  output logic       count_enabled,
  output logic       overflow,
  output logic       cmd_strobe
);

  localparam int         NBYTES   = CNT_WIDTH / 8;
  localparam logic [1:0] PTR_LAST = 2'(NBYTES - 1);

  localparam logic [7:0] OP_NOP          = 8'h00;
  localparam logic [7:0] OP_CLEAR        = 8'h01;
  localparam logic [7:0] OP_SNAPSHOT     = 8'h02;
  localparam logic [7:0] OP_READ_NEXT    = 8'h03;
  localparam logic [7:0] OP_ENABLE       = 8'h04;
  localparam logic [7:0] OP_DISABLE      = 8'h05;
  localparam logic [7:0] OP_SET_PRESCALE = 8'h10;

  typedef enum logic {
    IDLE,
    ARG
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] ce0_sync;
  logic                   ce0_dly;
  logic [SYNC_STAGES-1:0] evt_sync;
  logic                   evt_dly;
  logic                   byte_edge;
  logic                   evt_edge;

  logic [7:0]           cmd_reg;
  logic [CNT_WIDTH-1:0] count, count_nxt;
  logic [CNT_WIDTH-1:0] snap, snap_nxt;
  logic [CNT_WIDTH-1:0] snap_shift;
  logic [7:0]           pre_cnt, pre_cnt_nxt;
  logic [7:0]           prescale, prescale_nxt;
  logic [1:0]           ptr, ptr_nxt;
  logic                 bad_cmd, bad_cmd_nxt;
  logic                 overflow_nxt;
  logic                 enabled_nxt;
  logic [7:0]           dout_nxt;
  logic                 exec_idle;
  logic                 exec_arg;
  logic                 count_tick;

  // ce0 idles high, so its synchronizer resets to 1 to avoid a phantom byte on reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ce0_sync <= '1;
      ce0_dly  <= 1'b1;
      evt_sync <= '0;
      evt_dly  <= 1'b0;
    end else begin
      ce0_sync <= {ce0_sync[SYNC_STAGES-2:0], ce0};
      ce0_dly  <= ce0_sync[SYNC_STAGES-1];
      evt_sync <= {evt_sync[SYNC_STAGES-2:0], event_in};
      evt_dly  <= evt_sync[SYNC_STAGES-1];
    end
  end

  assign byte_edge = ce0_sync[SYNC_STAGES-1] & ~ce0_dly;
  assign evt_edge  = evt_sync[SYNC_STAGES-1] & ~evt_dly;

  // The strobe marks the cycle in which cmd_reg holds a fresh byte to execute.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_reg    <= 8'h00;
      cmd_strobe <= 1'b0;
    end else begin
      cmd_strobe <= byte_edge;
      if (byte_edge) begin
        cmd_reg <= data_incoming;
      end
    end
  end

  assign exec_idle = cmd_strobe && (state == IDLE);
  assign exec_arg  = cmd_strobe && (state == ARG);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (exec_arg) begin
      state_nxt = IDLE;
    end else if (exec_idle && (cmd_reg == OP_SET_PRESCALE)) begin
      state_nxt = ARG;
    end
  end

  assign count_tick = evt_edge && count_enabled && (pre_cnt == prescale);
  assign snap_shift = snap >> {ptr, 3'b000};

  // Event counting is applied first so that CLEAR and the operand load take priority over it.
  always_comb begin
    count_nxt    = count;
    snap_nxt     = snap;
    pre_cnt_nxt  = pre_cnt;
    prescale_nxt = prescale;
    ptr_nxt      = ptr;
    bad_cmd_nxt  = bad_cmd;
    overflow_nxt = overflow;
    enabled_nxt  = count_enabled;
    dout_nxt     = data_outgoing;

    if (evt_edge && count_enabled) begin
      pre_cnt_nxt = (pre_cnt == prescale) ? 8'd0 : pre_cnt + 8'd1;
    end
    if (count_tick) begin
      count_nxt = count + 1'b1;
      if (count == '1) begin
        overflow_nxt = 1'b1;
      end
    end

    if (exec_arg) begin
      prescale_nxt = cmd_reg;
      pre_cnt_nxt  = 8'd0;
    end

    if (exec_idle) begin
      case (cmd_reg)
        OP_NOP: begin
        end
        OP_CLEAR: begin
          count_nxt    = '0;
          pre_cnt_nxt  = 8'd0;
          overflow_nxt = 1'b0;
          bad_cmd_nxt  = 1'b0;
          ptr_nxt      = 2'd0;
        end
        OP_SNAPSHOT: begin
          snap_nxt = count;
          ptr_nxt  = 2'd0;
        end
        OP_READ_NEXT: begin
          ptr_nxt = (ptr == PTR_LAST) ? 2'd0 : ptr + 2'd1;
        end
        OP_ENABLE: begin
          enabled_nxt = 1'b1;
        end
        OP_DISABLE: begin
          enabled_nxt = 1'b0;
        end
        OP_SET_PRESCALE: begin
        end
        default: begin
          bad_cmd_nxt = 1'b1;
        end
      endcase
    end

    // Status reflects the state after this command has taken effect.
    if (cmd_strobe) begin
      if (exec_idle && (cmd_reg == OP_READ_NEXT)) begin
        dout_nxt = snap_shift[7:0];
      end else begin
        dout_nxt = {enabled_nxt, overflow_nxt, bad_cmd_nxt, 1'b0, ptr_nxt, 2'b10};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count         <= '0;
      snap          <= '0;
      pre_cnt       <= 8'd0;
      prescale      <= 8'd0;
      ptr           <= 2'd0;
      bad_cmd       <= 1'b0;
      overflow      <= 1'b0;
      count_enabled <= 1'b0;
      data_outgoing <= 8'h02;
    end else begin
      count         <= count_nxt;
      snap          <= snap_nxt;
      pre_cnt       <= pre_cnt_nxt;
      prescale      <= prescale_nxt;
      ptr           <= ptr_nxt;
      bad_cmd       <= bad_cmd_nxt;
      overflow      <= overflow_nxt;
      count_enabled <= enabled_nxt;
      data_outgoing <= dout_nxt;
    end
  end

endmodule
